// File: rtl/io_interrupt_unit.sv
// io_interrupt_unit: multi-channel I/O flag unit with maskable, fixed-priority
// interrupt request for the accumulator CPU. Each input channel buffers one
// device word behind an FGI flag. Each output channel holds one CPU word
// behind an FGO flag. The R flip-flop latches the lowest pending source and
// holds it until the CPU acknowledges.
module io_interrupt_unit #(
    parameter int DATA_W = 16,
    parameter int NCH    = 4,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    // device input channels
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    // device output channels
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    // CPU data side
    input  logic [CH_W-1:0]       sel,
    input  logic                  cpu_inp,
    input  logic                  cpu_out,
    input  logic [DATA_W-1:0]     bus_in,
    output logic [DATA_W-1:0]     inpr_out,
    output logic                  fgi_sel,
    output logic                  fgo_sel,
    // CPU interrupt side
    input  logic                  ion,
    input  logic                  iof,
    input  logic                  mask_we,
    input  logic [2*NCH-1:0]      mask_in,
    output logic                  ien,
    output logic                  intr_req,
    output logic [CH_W:0]         intr_vector,
    input  logic                  intr_ack,
    output logic                  out_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_e;

    logic [NCH-1:0][DATA_W-1:0] inpr_q, inpr_d;
    logic [NCH-1:0][DATA_W-1:0] outr_q, outr_d;
    logic [NCH-1:0]             fgi_q, fgi_d;
    logic [NCH-1:0]             fgo_q, fgo_d;
    logic [2*NCH-1:0]           mask_q, mask_d;
    logic                       ien_q, ien_d;
    logic                       out_err_q, out_err_d;
    logic [CH_W:0]              vec_q, vec_d;
    irq_state_e                 state_q, state_d;

    logic                       sel_ok;
    logic [CH_W-1:0]            sel_idx;
    logic [2*NCH-1:0]           pend;
    logic                       req_go;

    // Lowest set bit of the pending vector: inputs occupy the low half, so an
    // input always beats an output, and a lower channel beats a higher one.
    function automatic logic [CH_W:0] first_pending(input logic [2*NCH-1:0] p);
        logic [CH_W:0] v;
        v = '0;
        for (int i = 2*NCH-1; i >= 0; i--) begin
            if (p[i]) begin
                if (i >= NCH) begin
                    v = {1'b1, CH_W'(i - NCH)};
                end else begin
                    v = {1'b0, CH_W'(i)};
                end
            end
        end
        return v;
    endfunction

    // Decode the CPU channel select; out-of-range selects act on nothing.
    always_comb begin
        sel_ok  = (int'(sel) < NCH);
        sel_idx = sel_ok ? sel : '0;
    end

    // Input channels: a device fills an empty buffer, and the CPU INP empties it.
    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[i] && !fgi_q[i]) begin
                inpr_d[i] = in_data[i*DATA_W +: DATA_W];
                fgi_d[i]  = 1'b1;
            end
        end
        // in_ready is low while FGI is set, so this clear never meets a fill
        if (cpu_inp && sel_ok && fgi_q[sel_idx]) begin
            fgi_d[sel_idx] = 1'b0;
        end
    end

    // Output channels: the CPU OUT fills an empty slot, and a device handshake frees it.
    always_comb begin
        outr_d    = outr_q;
        fgo_d     = fgo_q;
        out_err_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!fgo_q[i] && out_ready[i]) begin
                fgo_d[i] = 1'b1;
            end
        end
        if (cpu_out && sel_ok) begin
            if (fgo_q[sel_idx]) begin
                outr_d[sel_idx] = bus_in;
                fgo_d[sel_idx]  = 1'b0;
            end else begin
                // previous word not yet consumed: keep it and flag the overrun
                out_err_d = 1'b1;
            end
        end
    end

    // Interrupt enable, mask and vector capture, all from the registered flags.
    always_comb begin
        pend   = {fgo_q & mask_q[2*NCH-1:NCH], fgi_q & mask_q[NCH-1:0]};
        req_go = (state_q == IDLE) && ien_q && (|pend) && !intr_ack;
        mask_d = mask_we ? mask_in : mask_q;

        ien_d = ien_q;
        if (ion) begin
            ien_d = 1'b1;
        end
        // iof and acknowledge both override ion
        if (iof || intr_ack) begin
            ien_d = 1'b0;
        end

        vec_d = req_go ? first_pending(pend) : vec_q;
    end

    // R state machine next-state: only an acknowledge releases a request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_go)   state_d = REQ;
            REQ:     if (intr_ack) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Output decode: flag views, selected-channel mux and the R flip-flop.
    always_comb begin
        in_ready    = ~fgi_q;
        out_valid   = ~fgo_q;
        out_data    = outr_q;
        inpr_out    = sel_ok ? inpr_q[sel_idx] : '0;
        fgi_sel     = sel_ok ? fgi_q[sel_idx]  : 1'b0;
        fgo_sel     = sel_ok ? fgo_q[sel_idx]  : 1'b0;
        ien         = ien_q;
        intr_req    = (state_q == REQ);
        intr_vector = vec_q;
        out_err     = out_err_q;
    end

    // State register: synchronous reset returns every flop to its idle value.
    always_ff @(posedge clk) begin
        if (reset) begin
            inpr_q    <= '0;
            outr_q    <= '0;
            fgi_q     <= '0;
            fgo_q     <= '1;
            mask_q    <= '0;
            ien_q     <= 1'b0;
            out_err_q <= 1'b0;
            vec_q     <= '0;
            state_q   <= IDLE;
        end else begin
            inpr_q    <= inpr_d;
            outr_q    <= outr_d;
            fgi_q     <= fgi_d;
            fgo_q     <= fgo_d;
            mask_q    <= mask_d;
            ien_q     <= ien_d;
            out_err_q <= out_err_d;
            vec_q     <= vec_d;
            state_q   <= state_d;
        end
    end

endmodule

// File: tb/tb_io_interrupt_unit.sv
// Testbench for io_interrupt_unit: directed vectors with literal expectations,
// plus a per-cycle comparison against a behavioural model of the unit.
module tb_io_interrupt_unit;

    localparam int DATA_W = 16;
    localparam int NCH    = 4;
    localparam int CH_W   = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NCH*DATA_W-1:0] in_data;
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_ready;
    logic [NCH*DATA_W-1:0] out_data;
    logic [NCH-1:0]        out_valid;
    logic [NCH-1:0]        out_ready;
    logic [CH_W-1:0]       sel;
    logic                  cpu_inp;
    logic                  cpu_out;
    logic [DATA_W-1:0]     bus_in;
    logic [DATA_W-1:0]     inpr_out;
    logic                  fgi_sel;
    logic                  fgo_sel;
    logic                  ion;
    logic                  iof;
    logic                  mask_we;
    logic [2*NCH-1:0]      mask_in;
    logic                  ien;
    logic                  intr_req;
    logic [CH_W:0]         intr_vector;
    logic                  intr_ack;
    logic                  out_err;

    always #5 clk = ~clk;

    io_interrupt_unit #(.DATA_W(DATA_W), .NCH(NCH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .cpu_inp(cpu_inp), .cpu_out(cpu_out), .bus_in(bus_in),
        .inpr_out(inpr_out), .fgi_sel(fgi_sel), .fgo_sel(fgo_sel),
        .ion(ion), .iof(iof), .mask_we(mask_we), .mask_in(mask_in),
        .ien(ien), .intr_req(intr_req), .intr_vector(intr_vector),
        .intr_ack(intr_ack), .out_err(out_err)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_inpr [NCH];
    logic [DATA_W-1:0] m_outr [NCH];
    bit                m_fgi  [NCH];
    bit                m_fgo  [NCH];
    bit                m_imask[NCH];
    bit                m_omask[NCH];
    bit                m_ien, m_r, m_err;
    int                m_vec;

    always @(posedge clk) begin : model_step
        logic [DATA_W-1:0] n_inpr [NCH];
        logic [DATA_W-1:0] n_outr [NCH];
        bit                n_fgi  [NCH];
        bit                n_fgo  [NCH];
        bit                n_ien, n_r, n_err, found;
        int                n_vec, s;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_inpr[c] = '0; m_outr[c] = '0; m_fgi[c] = 0; m_fgo[c] = 1;
                m_imask[c] = 0; m_omask[c] = 0;
            end
            m_ien = 0; m_r = 0; m_err = 0; m_vec = 0;
        end else begin
            n_inpr = m_inpr; n_outr = m_outr; n_fgi = m_fgi; n_fgo = m_fgo;
            s = int'(sel);
            for (int c = 0; c < NCH; c++) begin
                if (in_valid[c] && !m_fgi[c]) begin
                    n_inpr[c] = in_data[c*DATA_W +: DATA_W];
                    n_fgi[c]  = 1;
                end
                if (out_ready[c] && !m_fgo[c]) n_fgo[c] = 1;
            end
            if (cpu_inp && s < NCH && m_fgi[s]) n_fgi[s] = 0;
            n_err = 0;
            if (cpu_out && s < NCH) begin
                if (m_fgo[s]) begin
                    n_outr[s] = bus_in;
                    n_fgo[s]  = 0;
                end else begin
                    n_err = 1;
                end
            end
            n_ien = m_ien;
            if (ion) n_ien = 1;
            if (iof || intr_ack) n_ien = 0;
            n_r = m_r; n_vec = m_vec; found = 0;
            if (!m_r) begin
                for (int c = 0; c < NCH; c++)
                    if (!found && m_fgi[c] && m_imask[c]) begin found = 1; n_vec = c; end
                for (int c = 0; c < NCH; c++)
                    if (!found && m_fgo[c] && m_omask[c]) begin found = 1; n_vec = (1 << CH_W) + c; end
                if (m_ien && found && !intr_ack) n_r = 1;
                else n_vec = m_vec;
            end else if (intr_ack) begin
                n_r = 0;
            end
            if (mask_we)
                for (int c = 0; c < NCH; c++) begin
                    m_imask[c] = mask_in[c];
                    m_omask[c] = mask_in[NCH + c];
                end
            m_inpr = n_inpr; m_outr = n_outr; m_fgi = n_fgi; m_fgo = n_fgo;
            m_ien = n_ien; m_r = n_r; m_vec = n_vec; m_err = n_err;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [NCH-1:0]        e_rdy, e_ov;
        logic [NCH*DATA_W-1:0] e_od;
        logic [DATA_W-1:0]     e_inpr;
        logic                  e_fgi, e_fgo;
        logic [CH_W:0]         e_vec;
        int                    s;
        if (cmp_en) begin
            s = int'(sel);
            for (int c = 0; c < NCH; c++) begin
                e_rdy[c] = !m_fgi[c];
                e_ov[c]  = !m_fgo[c];
                e_od[c*DATA_W +: DATA_W] = m_outr[c];
            end
            e_inpr = (s < NCH) ? m_inpr[s] : '0;
            e_fgi  = (s < NCH) ? m_fgi[s]  : 1'b0;
            e_fgo  = (s < NCH) ? m_fgo[s]  : 1'b0;
            e_vec  = m_vec[CH_W:0];
            chk("m_in_ready",  in_ready,    e_rdy);
            chk("m_out_valid", out_valid,   e_ov);
            chk("m_out_data",  out_data,    e_od);
            chk("m_inpr_out",  inpr_out,    e_inpr);
            chk("m_fgi_sel",   fgi_sel,     e_fgi);
            chk("m_fgo_sel",   fgo_sel,     e_fgo);
            chk("m_ien",       ien,         m_ien);
            chk("m_intr_req",  intr_req,    m_r);
            chk("m_vector",    intr_vector, e_vec);
            chk("m_out_err",   out_err,     m_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = '0; out_ready = '0; sel = '0;
        cpu_inp = 0; cpu_out = 0; bus_in = '0; ion = 0; iof = 0;
        mask_we = 0; mask_in = '0; intr_ack = 0;
        cyc();
        cmp_en = 1'b1;
        cyc();
        chk("rst_in_ready",  in_ready,    4'b1111);
        chk("rst_out_valid", out_valid,   4'b0000);
        chk("rst_fgo_sel",   fgo_sel,     1'b1);
        chk("rst_ien",       ien,         1'b0);
        chk("rst_intr_req",  intr_req,    1'b0);
        chk("rst_inpr_out",  inpr_out,    16'h0000);
        reset = 1'b0;

        // device write on ch2, back-pressure, CPU read
        in_data[2*DATA_W +: DATA_W] = 16'hA5A5; in_valid = 4'b0100;
        cyc();
        chk("ch2_fgi_set", in_ready, 4'b1011);
        in_data[2*DATA_W +: DATA_W] = 16'hBEEF;
        cyc();
        sel = 2'd2; #1;
        chk("ch2_held_off", inpr_out, 16'hA5A5);
        chk("ch2_fgi_sel",  fgi_sel,  1'b1);
        in_valid = '0; cpu_inp = 1; #1;
        chk("ch2_inp_read", inpr_out, 16'hA5A5);
        cyc();
        cpu_inp = 0; #1;
        chk("ch2_fgi_clr", fgi_sel,  1'b0);
        chk("ch2_ready",   in_ready, 4'b1111);

        // CPU output on ch1, overrun, device consume
        sel = 2'd1; bus_in = 16'h1234; cpu_out = 1;
        cyc();
        bus_in = 16'h5678; #1;
        chk("ch1_out_valid", out_valid, 4'b0010);
        chk("ch1_out_data",  out_data[1*DATA_W +: DATA_W], 16'h1234);
        cyc();
        cpu_out = 0; #1;
        chk("ch1_out_err",   out_err, 1'b1);
        chk("ch1_unchanged", out_data[1*DATA_W +: DATA_W], 16'h1234);
        cyc();
        chk("ch1_err_pulse", out_err, 1'b0);
        out_ready = 4'b0010;
        cyc();
        out_ready = '0; #1;
        chk("ch1_consumed", out_valid, 4'b0000);
        chk("ch1_fgo_sel",  fgo_sel,   1'b1);

        // input interrupts, ch3 and ch1 together
        mask_we = 1; mask_in = 8'h0F; ion = 1;
        cyc();
        mask_we = 0; ion = 0; #1;
        chk("in_irq_ien", ien, 1'b1);
        in_data[3*DATA_W +: DATA_W] = 16'h3333; in_data[1*DATA_W +: DATA_W] = 16'h1111;
        in_valid = 4'b1010;
        cyc();
        in_valid = '0; #1;
        chk("in_irq_lat0", intr_req, 1'b0);
        cyc();
        chk("in_irq_req", intr_req,    1'b1);
        chk("in_irq_vec", intr_vector, 3'b001);
        intr_ack = 1;
        cyc();
        intr_ack = 0; #1;
        chk("in_ack_req", intr_req, 1'b0);
        chk("in_ack_ien", ien,      1'b0);
        sel = 2'd1; cpu_inp = 1; #1;
        chk("ch1_inpr", inpr_out, 16'h1111);
        cyc();
        sel = 2'd3; #1;
        chk("ch3_inpr", inpr_out, 16'h3333);
        cyc();
        cpu_inp = 0;

        // output interrupts with all FGO set; ion and iof together
        mask_we = 1; mask_in = 8'hF0; ion = 1;
        cyc();
        mask_we = 0; ion = 0; #1;
        chk("out_irq_lat0", intr_req, 1'b0);
        cyc();
        chk("out_irq_req", intr_req,    1'b1);
        chk("out_irq_vec", intr_vector, 3'b100);
        ion = 1; iof = 1;
        cyc();
        ion = 0; iof = 0; #1;
        chk("ion_iof_ien",  ien,         1'b0);
        chk("iof_keeps_r",  intr_req,    1'b1);
        chk("iof_keep_vec", intr_vector, 3'b100);
        intr_ack = 1;
        cyc();
        intr_ack = 0; #1;
        chk("out_ack_req", intr_req, 1'b0);

        // acknowledge while idle still clears IEN
        mask_we = 1; mask_in = 8'h00; ion = 1;
        cyc();
        mask_we = 0; ion = 0; #1;
        chk("idle_ien_set", ien, 1'b1);
        intr_ack = 1;
        cyc();
        intr_ack = 0; #1;
        chk("idle_ack_ien", ien,      1'b0);
        chk("idle_ack_req", intr_req, 1'b0);

        // inputs beat outputs
        mask_we = 1; mask_in = 8'hFF; ion = 1;
        in_data[3*DATA_W +: DATA_W] = 16'hCAFE; in_valid = 4'b1000;
        cyc();
        mask_we = 0; ion = 0; in_valid = '0;
        cyc();
        chk("prio_req", intr_req,    1'b1);
        chk("prio_vec", intr_vector, 3'b011);
        intr_ack = 1;
        cyc();
        intr_ack = 0;

        // reset while a request is pending and FGI[0] is set
        ion = 1; in_data[0 +: DATA_W] = 16'h7777; in_valid = 4'b0001;
        cyc();
        ion = 0; in_valid = '0;
        cyc();
        sel = 2'd0; #1;
        chk("pre_rst_req",   intr_req,    1'b1);
        chk("pre_rst_vec",   intr_vector, 3'b000);
        chk("pre_rst_ready", in_ready,    4'b0110);
        chk("pre_rst_inpr",  inpr_out,    16'h7777);
        reset = 1;
        cyc();
        chk("mid_rst_ready", in_ready,    4'b1111);
        chk("mid_rst_req",   intr_req,    1'b0);
        chk("mid_rst_ien",   ien,         1'b0);
        chk("mid_rst_vec",   intr_vector, 3'b000);
        chk("mid_rst_inpr",  inpr_out,    16'h0000);
        chk("mid_rst_ov",    out_valid,   4'b0000);
        reset = 0;
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
